light_mode_controller: RTL and testbench
========================================

Name: light_mode_controller

Overview:
Sequencing and configuration controller for the bicycle rear-light datapath. It turns the next/faster/slower buttons into a mode select for the output mux and into per-blinker half-period values for the fast and slow programmable blinkers. It also auto-switches the light off after a programmable idle time, counted in beat pulses from the 32 Hz beat counter. It sits between the button inputs and the beat counter, blinkers and output mux.

Parameters:
RATE_W, 4, width of each half-period register (units: beats)
RATE_MIN, 1, lowest legal half-period; fast-blinker rate saturates here
RATE_MAX, 15, highest legal half-period; slow-blinker rate saturates here
FAST_INIT, 2, fast_rate value after reset
SLOW_INIT, 8, slow_rate value after reset
IDLE_W, 8, width of the idle timer
IDLE_BEATS, 255, beats without any button press before auto-off

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active low
next  in  1  mode-advance button, level, already synchronised
faster  in  1  rate-up button, level
slower  in  1  rate-down button, level
beat  in  1  one-cycle pulse from the beat counter (32 Hz)
mode  out  2  mux select: 00 OFF, 01 ON, 10 FAST, 11 SLOW
fast_rate  out  RATE_W  half-period for the fast blinker
slow_rate  out  RATE_W  half-period for the slow blinker
rate_load  out  1  one-cycle pulse; the blinker must reload its rate

Behaviour:
- Clock and reset: all state updates on the rising edge of clk. rst is sampled synchronously and is active low.
- Values while rst=0: mode=OFF, fast_rate=FAST_INIT, slow_rate=SLOW_INIT, rate_load=0, idle timer=0.
- Button-history registers are set to 1 during reset, so a button held through reset does not register as a press.
- Press detection: a press is the input sampled 1 in cycle n and 0 in cycle n-1.
  - The resulting action is visible on the outputs in cycle n+1 (one-cycle latency).
  - A held button yields exactly one press.
- Mode FSM on a next press: OFF->ON->FAST->SLOW->OFF (wraps).
- Rate changes:
  - faster press: decrements the half-period of the active blinker (FAST mode -> fast_rate, SLOW mode -> slow_rate).
  - slower press: increments it.
  - In OFF and ON, faster/slower change no rate.
- Saturation:
  - Decrement at RATE_MIN leaves the value unchanged, with no rate_load.
  - Increment at RATE_MAX leaves the value unchanged, with no rate_load.
  - Only the rate of the active mode ever changes.
- rate_load: high for exactly the one cycle in which a changed rate first appears on the outputs; otherwise 0.
- Simultaneous presses:
  - next together with faster or slower: next wins; the rate press is discarded.
  - faster and slower together without next: both are discarded; no rate change.
- Idle timer:
  - Held at 0 while mode=OFF.
  - In any other mode it increments on each beat pulse.
  - Any press (including discarded or ignored ones) clears it to 0 that cycle.
  - When the timer is at IDLE_BEATS-1 and beat=1: mode becomes OFF next cycle and the timer clears.
  - Rates are preserved through auto-off.
- Press vs. timeout in the same cycle: the press wins. The timer clears and mode follows the press.
- Timer arithmetic: unsigned, IDLE_W bits. IDLE_BEATS must be in 1..2^IDLE_W-1. The timer never wraps because timeout precedes overflow.
- Reset mid-operation: a one-cycle rst=0 pulse restores all reset values. An in-flight rate_load is dropped.
- Outputs are registered (no combinational path from input to output).

Decomposition:
- Shared package bicycle_pkg holds:
  - mode encodings MODE_OFF/ON/FAST/SLOW
  - default RATE_MIN/RATE_MAX/FAST_INIT/SLOW_INIT
  - the beat frequency constant, shared with the beat counter and blinkers.
- One sub-module is natural: button_press_detect (per-button history register plus rising-edge pulse, history preset on reset), instantiated three times.

Test Plan:
- Reset and mode cycling: hold rst=0 for 3 cycles, then release.
  - Expect mode=00, fast_rate=2, slow_rate=8, rate_load=0.
  - 4 next presses -> mode 01, 10, 11, 00, each one cycle after its press.
- Fast-rate saturation: in FAST mode, 3 faster presses.
  - Expect fast_rate 2->1 with one rate_load pulse, then stays 1 with no further rate_load.
  - slow_rate stays 8.
- Slow-rate saturation: in SLOW mode, 8 slower presses.
  - Expect slow_rate 8->15 over 7 presses with 7 rate_load pulses; the 8th press has no effect.
- Simultaneous buttons:
  - next+faster in FAST -> mode=SLOW, fast_rate unchanged.
  - faster+slower in SLOW -> no change, rate_load=0.
- Idle timeout with IDLE_BEATS=4: mode=ON, beat every 10 cycles.
  - mode=OFF after the 4th beat.
  - Repeat with a faster press on the 4th-beat cycle -> mode stays ON and the timer restarts.
- Held button and reset: hold next through a reset and after it -> no mode change. Then pulse rst=0 while mode=SLOW and slow_rate=12 -> mode=00, slow_rate=8.

Source files
------------

// File: rtl/bicycle_pkg.sv
// Shared constants and mode encodings for the bicycle rear-light datapath.
// Used by the mode controller, beat counter, blinkers and output mux.
package bicycle_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_ON   = 2'b01,
    MODE_FAST = 2'b10,
    MODE_SLOW = 2'b11
  } mode_e;

  localparam int unsigned DEF_RATE_MIN  = 1;
  localparam int unsigned DEF_RATE_MAX  = 15;
  localparam int unsigned DEF_FAST_INIT = 2;
  localparam int unsigned DEF_SLOW_INIT = 8;
  localparam int unsigned BEAT_HZ       = 32;

  // OFF -> ON -> FAST -> SLOW -> OFF relies on the encoding wrapping in 2 bits.
  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/button_press_detect.sv
// Rising-edge press detector for one already-synchronised button level.
// History presets to 1 in reset so a button held through reset is not a press.
module button_press_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  logic r_hist;

  always_ff @(posedge clk) begin
    if (!rst) r_hist <= 1'b1;
    else      r_hist <= i_btn;
  end

  assign o_press = i_btn & ~r_hist;

endmodule

// File: rtl/light_mode_controller.sv
// Mode sequencing, blinker half-period configuration and idle auto-off
// for the bicycle rear light; all outputs are registered.
module light_mode_controller
  import bicycle_pkg::*;
#(
  parameter int unsigned RATE_W     = 4,
  parameter int unsigned RATE_MIN   = DEF_RATE_MIN,
  parameter int unsigned RATE_MAX   = DEF_RATE_MAX,
  parameter int unsigned FAST_INIT  = DEF_FAST_INIT,
  parameter int unsigned SLOW_INIT  = DEF_SLOW_INIT,
  parameter int unsigned IDLE_W     = 8,
  parameter int unsigned IDLE_BEATS = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              next,
  input  logic              faster,
  input  logic              slower,
  input  logic              beat,
  output logic [1:0]        mode,
  output logic [RATE_W-1:0] fast_rate,
  output logic [RATE_W-1:0] slow_rate,
  output logic              rate_load
);

  localparam logic [RATE_W-1:0] C_MIN       = RATE_W'(RATE_MIN);
  localparam logic [RATE_W-1:0] C_MAX       = RATE_W'(RATE_MAX);
  localparam logic [RATE_W-1:0] C_FAST_INIT = RATE_W'(FAST_INIT);
  localparam logic [RATE_W-1:0] C_SLOW_INIT = RATE_W'(SLOW_INIT);
  localparam logic [IDLE_W-1:0] C_IDLE_LAST = IDLE_W'(IDLE_BEATS - 1);

  mode_e             r_mode;
  logic [RATE_W-1:0] r_fast;
  logic [RATE_W-1:0] r_slow;
  logic              r_load;
  logic [IDLE_W-1:0] r_idle;

  logic              w_press_next;
  logic              w_press_fast;
  logic              w_press_slow;
  logic              w_any_press;
  logic              w_active;
  logic              w_rate_dn;
  logic              w_rate_up;
  logic [RATE_W-1:0] w_cur;
  logic [RATE_W-1:0] w_rate_new;
  logic              w_rate_step;

  button_press_detect u_next (.clk(clk), .rst(rst), .i_btn(next),   .o_press(w_press_next));
  button_press_detect u_fast (.clk(clk), .rst(rst), .i_btn(faster), .o_press(w_press_fast));
  button_press_detect u_slow (.clk(clk), .rst(rst), .i_btn(slower), .o_press(w_press_slow));

  // faster and slower together cancel; saturated steps are not rate changes
  assign w_any_press = w_press_next | w_press_fast | w_press_slow;
  assign w_active    = (r_mode == MODE_FAST) || (r_mode == MODE_SLOW);
  assign w_rate_dn   = w_press_fast & ~w_press_slow;
  assign w_rate_up   = w_press_slow & ~w_press_fast;
  assign w_cur       = (r_mode == MODE_FAST) ? r_fast : r_slow;
  assign w_rate_new  = w_rate_dn ? (w_cur - 1'b1) : (w_cur + 1'b1);
  assign w_rate_step = w_active &
                       ((w_rate_dn & (w_cur != C_MIN)) | (w_rate_up & (w_cur != C_MAX)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mode <= MODE_OFF;
      r_fast <= C_FAST_INIT;
      r_slow <= C_SLOW_INIT;
      r_load <= 1'b0;
      r_idle <= '0;
    end else begin
      r_load <= 1'b0;
      if (w_press_next) begin
        r_mode <= next_mode(r_mode);
        r_idle <= '0;
      end else if (w_any_press) begin
        r_idle <= '0;
        if (w_rate_step) begin
          if (r_mode == MODE_FAST) r_fast <= w_rate_new;
          else                     r_slow <= w_rate_new;
          r_load <= 1'b1;
        end
      end else if (r_mode == MODE_OFF) begin
        r_idle <= '0;
      end else if (beat) begin
        if (r_idle == C_IDLE_LAST) begin
          r_mode <= MODE_OFF;
          r_idle <= '0;
        end else begin
          r_idle <= r_idle + 1'b1;
        end
      end
    end
  end

  assign mode      = r_mode;
  assign fast_rate = r_fast;
  assign slow_rate = r_slow;
  assign rate_load = r_load;

endmodule

// File: tb/tb_light_mode_controller.sv
// Directed and randomized bench for light_mode_controller against a
// behavioural model that tracks mode index, rates and beats since last press.
module tb_light_mode_controller;

  localparam int IDLE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       next = 1'b0;
  logic       faster = 1'b0;
  logic       slower = 1'b0;
  logic       beat = 1'b0;
  logic [1:0] mode;
  logic [3:0] fast_rate;
  logic [3:0] slow_rate;
  logic       rate_load;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_mode = 0;
  int m_fast = 2;
  int m_slow = 8;
  int m_load = 0;
  int m_beats = 0;
  bit m_pn = 1'b1;
  bit m_pf = 1'b1;
  bit m_ps = 1'b1;

  light_mode_controller #(
    .RATE_W    (4),
    .RATE_MIN  (1),
    .RATE_MAX  (15),
    .FAST_INIT (2),
    .SLOW_INIT (8),
    .IDLE_W    (8),
    .IDLE_BEATS(IDLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .next     (next),
    .faster   (faster),
    .slower   (slower),
    .beat     (beat),
    .mode     (mode),
    .fast_rate(fast_rate),
    .slow_rate(slow_rate),
    .rate_load(rate_load)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit n, input bit f, input bit s, input bit b);
    bit pn, pf, ps;
    int target, nv;
    if (!r) begin
      m_mode = 0; m_fast = 2; m_slow = 8; m_load = 0; m_beats = 0;
      m_pn = 1'b1; m_pf = 1'b1; m_ps = 1'b1;
      return;
    end
    pn = n && !m_pn;
    pf = f && !m_pf;
    ps = s && !m_ps;
    m_pn = n; m_pf = f; m_ps = s;
    m_load = 0;
    if (pn || pf || ps || m_mode == 0) begin
      m_beats = 0;
      if (pn) begin
        m_mode = (m_mode + 1) % 4;
      end else if (pf != ps && m_mode >= 2) begin
        target = (m_mode == 2) ? m_fast : m_slow;
        nv = pf ? target - 1 : target + 1;
        if (nv >= 1 && nv <= 15) begin
          if (m_mode == 2) m_fast = nv; else m_slow = nv;
          m_load = 1;
        end
      end
    end else if (b) begin
      m_beats++;
      if (m_beats == IDLE) begin
        m_mode = 0;
        m_beats = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit n, input bit f, input bit s, input bit b);
    rst = r; next = n; faster = f; slower = s; beat = b;
    @(posedge clk);
    model_update(r, n, f, s, b);
    #1;
    check_eq("mode", int'(mode), m_mode);
    check_eq("fast_rate", int'(fast_rate), m_fast);
    check_eq("slow_rate", int'(slow_rate), m_slow);
    check_eq("rate_load", int'(rate_load), m_load);
  endtask

  task automatic tap(input bit n, input bit f, input bit s);
    step(1'b1, n, f, s, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit rn, rf, rs;

    // reset and mode cycling
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_mode", int'(mode), 0);
    check_eq("rst_fast", int'(fast_rate), 2);
    check_eq("rst_slow", int'(slow_rate), 8);
    check_eq("rst_load", int'(rate_load), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tap(1'b1, 1'b0, 1'b0);
      check_eq("cycle_mode", int'(mode), k % 4);
    end

    // fast-rate saturation
    tap(1'b1, 1'b0, 1'b0);
    tap(1'b1, 1'b0, 1'b0);
    check_eq("in_fast", int'(mode), 2);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("fsat_load", int'(rate_load), (k == 0) ? 1 : 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("fsat_rate", int'(fast_rate), 1);
    end
    check_eq("fsat_slow", int'(slow_rate), 8);

    // slow-rate saturation
    tap(1'b1, 1'b0, 1'b0);
    check_eq("in_slow", int'(mode), 3);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("ssat_load", int'(rate_load), (k <= 7) ? 1 : 0);
      check_eq("ssat_rate", int'(slow_rate), (k <= 7) ? 8 + k : 15);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // simultaneous buttons
    repeat (3) tap(1'b1, 1'b0, 1'b0);
    check_eq("back_fast", int'(mode), 2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("nf_mode", int'(mode), 3);
    check_eq("nf_fast", int'(fast_rate), 1);
    check_eq("nf_load", int'(rate_load), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("fs_slow", int'(slow_rate), 15);
    check_eq("fs_load", int'(rate_load), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // idle timeout
    tap(1'b1, 1'b0, 1'b0);
    tap(1'b1, 1'b0, 1'b0);
    check_eq("to_on", int'(mode), 1);
    for (int k = 1; k <= 4; k++) begin
      repeat (9) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("to_mode", int'(mode), (k < 4) ? 1 : 0);
    end
    check_eq("to_keep_slow", int'(slow_rate), 15);
    tap(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      repeat (9) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, (k == 4), 1'b0, 1'b1);
      check_eq("tp_mode", int'(mode), 1);
    end
    for (int k = 1; k <= 4; k++) begin
      repeat (9) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("tr_mode", int'(mode), (k < 4) ? 1 : 0);
    end

    // held button through reset, then mid-operation reset
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("held_mode", int'(mode), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tap(1'b1, 1'b0, 1'b0);
    repeat (4) tap(1'b0, 1'b0, 1'b1);
    check_eq("pre_mode", int'(mode), 3);
    check_eq("pre_slow", int'(slow_rate), 12);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("pulse_mode", int'(mode), 0);
    check_eq("pulse_slow", int'(slow_rate), 8);
    check_eq("pulse_load", int'(rate_load), 0);

    // randomized traffic
    rn = 1'b0; rf = 1'b0; rs = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(3) == 0) rn = ~rn;
      if ($urandom_range(2) == 0) rf = ~rf;
      if ($urandom_range(2) == 0) rs = ~rs;
      step(($urandom_range(149) != 0), rn, rf, rs, ($urandom_range(3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
